// File: rtl/led_sr_driver_pkg.sv
// Shared definitions for the LED shift-register transmitter: state encoding,
// default geometry and a counter-width helper.
package led_sr_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DIV   = 4;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SHIFT_LO = 2'd1;
    localparam logic [1:0] SHIFT_HI = 2'd2;
    localparam logic [1:0] LATCH    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = IDLE,
        ST_SHIFT_LO = SHIFT_LO,
        ST_SHIFT_HI = SHIFT_HI,
        ST_LATCH    = LATCH
    } state_t;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_sr_driver_if.sv
// Request handshake between the LED blinker (master) and the transmitter (slave).
interface led_sr_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] val;
    logic             go;
    logic             rdy;

    modport master (output val, output go, input rdy);
    modport slave  (input val, input go, output rdy);
endinterface

// File: rtl/led_sr_driver_div.sv
// Phase timer: counts DIV cycles after each load; done is high on the last
// cycle of the phase. The counter parks at zero instead of wrapping.
module led_sr_div
    import led_sr_pkg::*;
#(
    parameter int DIV = DEFAULT_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);
    localparam int             CW     = cnt_width(DIV);
    localparam logic [CW-1:0]  RELOAD = CW'(DIV - 1);

    logic [CW-1:0] cnt_reg;

    // Reload at the start of every phase, then count down to zero and hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= RELOAD;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign done = (cnt_reg == '0);
endmodule

// File: rtl/led_sr_driver.sv
// LED shift-register transmitter: shifts a parallel word MSB-first on
// sr_data/sr_clk, then pulses sr_latch so the LEDs update together.
// Optional feature macro: LED_SR_SKIP_UNCHANGED_EN -- when defined, a word
// equal to the last latched word is consumed without any pin activity.
module led_sr_driver
    import led_sr_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIV   = DEFAULT_DIV
) (
    input  logic        clk,
    input  logic        rst,
    led_sr_if.slave     bus,
    output logic        sr_data,
    output logic        sr_clk,
    output logic        sr_latch
);
    localparam int            BW       = cnt_width(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           state_reg;
    logic             rdy_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [BW-1:0]    bit_cnt_reg;
    logic             div_done;
    logic             div_load;
    logic             accept;
    logic             start;
    logic             skip_hit;

    assign bus.rdy    = rdy_reg;
    assign shift_next = shift_reg << 1;
    assign accept     = (state_reg == ST_IDLE) && bus.go && rdy_reg;
    assign start      = accept && !skip_hit;
    assign div_load   = start || ((state_reg != ST_IDLE) && div_done);

`ifdef LED_SR_SKIP_UNCHANGED_EN
    logic [WIDTH-1:0] word_reg;
    logic [WIDTH-1:0] last_val_reg;
    logic             last_valid_reg;

    assign skip_hit = last_valid_reg && (bus.val == last_val_reg);

    // Remember the word in flight and record it as latched on entry to LATCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_reg       <= '0;
            last_val_reg   <= '0;
            last_valid_reg <= 1'b0;
        end else begin
            if (start) begin
                word_reg <= bus.val;
            end
            if ((state_reg == ST_SHIFT_HI) && div_done && (bit_cnt_reg == '0)) begin
                last_val_reg   <= word_reg;
                last_valid_reg <= 1'b1;
            end
        end
    end
`else
    assign skip_hit = 1'b0;
`endif

    led_sr_div #(.DIV(DIV)) u_div (
        .clk  (clk),
        .rst  (rst),
        .load (div_load),
        .done (div_done)
    );

    // Transfer sequencer: each phase lasts DIV cycles, all pins are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            rdy_reg     <= 1'b1;
            sr_data     <= 1'b0;
            sr_clk      <= 1'b0;
            sr_latch    <= 1'b0;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        shift_reg   <= bus.val;
                        sr_data     <= bus.val[WIDTH-1];
                        bit_cnt_reg <= LAST_BIT;
                        rdy_reg     <= 1'b0;
                        state_reg   <= ST_SHIFT_LO;
                    end
                end
                ST_SHIFT_LO: begin
                    if (div_done) begin
                        sr_clk    <= 1'b1;
                        state_reg <= ST_SHIFT_HI;
                    end
                end
                ST_SHIFT_HI: begin
                    if (div_done) begin
                        sr_clk <= 1'b0;
                        if (bit_cnt_reg == '0) begin
                            sr_latch  <= 1'b1;
                            state_reg <= ST_LATCH;
                        end else begin
                            shift_reg   <= shift_next;
                            sr_data     <= shift_next[WIDTH-1];
                            bit_cnt_reg <= bit_cnt_reg - 1'b1;
                            state_reg   <= ST_SHIFT_LO;
                        end
                    end
                end
                ST_LATCH: begin
                    if (div_done) begin
                        sr_latch  <= 1'b0;
                        rdy_reg   <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/led_sr_driver.md
# led_sr_driver

Serial shift-register transmitter feeding the external LED latch (74HC595-class) on the E1 front panel. It accepts a parallel LED word through a `val`/`go`/`rdy` handshake from the LED blinker and shifts it out MSB-first on `sr_data`/`sr_clk`. It then pulses `sr_latch` so all LEDs update atomically. It sits between the blinker and the board pins, in the system clock domain.

## Interface
- `WIDTH`, 8: number of bits per transfer (≥1).
- `DIV`, 4: system-clock cycles per `sr_clk` half-period and per latch pulse (≥1).
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `val` in WIDTH: word to shift, bit WIDTH-1 first.
- `go` in 1: transfer request.
- `rdy` out 1: high when idle; a transfer is accepted on any cycle with `go & rdy`.
- `sr_data` out 1: serial data to the shift register.
- `sr_clk` out 1: shift clock; the shift register samples on its rising edge.
- `sr_latch` out 1: storage-register latch pulse, active high.

## Operation
- Reset values: `rdy`=1, `sr_data`=0, `sr_clk`=0, `sr_latch`=0; state IDLE. All outputs are registered.
- States are IDLE, SHIFT_LO, SHIFT_HI and LATCH.
- **IDLE**
  - On `go & rdy`: capture `val` into the shift register; `sr_data` ← `val[WIDTH-1]`; bit_cnt ← WIDTH-1; div_cnt ← DIV-1; `rdy` ← 0; go to SHIFT_LO.
- **SHIFT_LO**
  - `sr_clk`=0 for DIV cycles.
  - Then `sr_clk` ← 1; go to SHIFT_HI.
- **SHIFT_HI**
  - `sr_clk`=1 for DIV cycles.
  - At the end, `sr_clk` ← 0.
  - If bit_cnt=0: `sr_latch` ← 1; go to LATCH.
  - Otherwise: shift left, `sr_data` ← next bit, bit_cnt decrements; go to SHIFT_LO.
- **LATCH**
  - `sr_latch`=1 for DIV cycles.
  - Then `sr_latch` ← 0, `rdy` ← 1; go to IDLE.
  - `sr_data` keeps the last bit.
- `go` while busy: ignored, not queued. Requesters hold `go` until they see `rdy`.
- `val` changes while busy: no effect, because the word was captured at accept.
- `go` held high across completion: a new transfer is accepted on the first cycle `rdy`=1.
- Reset mid-transfer: outputs return to reset values immediately. The external storage register keeps its old value because no latch pulse occurred.
- div_cnt is ⌈log2(DIV)⌉ bits wide; bit_cnt is ⌈log2(WIDTH)⌉ bits wide (minimum 1). Both count down and reload, with no wrap beyond terminal.

## Timing
- Accept edge to `rdy` rising: exactly 2·WIDTH·DIV + DIV cycles (68 cycles with the defaults).
- `sr_data` is stable for DIV cycles before, and DIV cycles after, each `sr_clk` rising edge. The last bit stays stable through LATCH.
- `sr_latch` rises on the same edge that `sr_clk` falls after the last bit.
- Minimum back-to-back period: 2·WIDTH·DIV + DIV + 1 cycles (one IDLE cycle with `rdy`=1).

## Configuration
- `LED_SR_SKIP_UNCHANGED_EN`
- **Defined**
  - The block keeps `last_val`, the last word latched, plus a valid flag; the flag is cleared by reset.
  - An accepted word equal to `last_val` while the flag is set is consumed with no pin activity. `rdy` stays 1.
  - The flag is set, and `last_val` updated, on entry to LATCH.
  - A reset mid-transfer leaves the flag clear.
- **Undefined**
  - Every accepted word is shifted and latched.

## Structure
- Shared package `led_sr_pkg` holds the state encoding localparams (IDLE=0, SHIFT_LO=1, SHIFT_HI=2, LATCH=3) and the default WIDTH/DIV.
- One sub-module, `led_sr_div`: a DIV-cycle down-counter with `load` input and `done` strobe. It is reused for every phase.

## Test plan
- Reset, then `go` with `val`=8'hA5 (DIV=4):
  - `rdy` falls next cycle.
  - `sr_data` sequence on `sr_clk` rising edges is 1,0,1,0,0,1,0,1.
  - There are exactly 8 rising edges.
  - `sr_latch` is high for 4 cycles.
  - `rdy` returns after 68 cycles.
- `go` held continuously with `val` changing to 8'h3C mid-transfer: the first transfer still emits A5. The second is accepted on the first `rdy`=1 cycle and emits 3C.
- `go` pulsed while busy: no extra transfer; the `rdy` timing is unchanged.
- Assert `rst` during bit 4: all outputs go to reset values in the same cycle and no `sr_latch` pulse occurs. The next transfer of 8'hFF completes normally.
- With `LED_SR_SKIP_UNCHANGED_EN`:
  - Send 8'h12 twice: the second send produces no `sr_clk` edges and `rdy` never falls.
  - Send 8'h13: a full transfer.
  - After reset, 8'h13 is shifted again.
- DIV=1, WIDTH=1, `val`=1: `sr_clk` is high for 1 cycle, `sr_latch` is high for 1 cycle, and `rdy` returns after 3 cycles.
